// File: rtl/wb_cmd_sequencer_if.sv
// Bundle of command, downstream-bus and response signals around wb_cmd_sequencer.
// The master modport is the sequencer's own view; slave is the surrounding logic.
interface wb_cmd_sequencer_if #(
  parameter int data_wl = 16,
  parameter int adr_wl  = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_we;
  logic [adr_wl-1:0]  cmd_addr;
  logic [data_wl-1:0] cmd_data;
  logic [adr_wl-1:0]  addr_o;
  logic [data_wl-1:0] data_o;
  logic               we_o;
  logic               start_o;
  logic               busy_i;
  logic               valid_i;
  logic [data_wl-1:0] rdata_i;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [data_wl-1:0] rsp_data;
  logic [7:0]         wr_done_cnt;
  logic               err_o;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_data, busy_i, valid_i, rdata_i, rsp_ready,
    output cmd_ready, addr_o, data_o, we_o, start_o, rsp_valid, rsp_data, wr_done_cnt, err_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_data, busy_i, valid_i, rdata_i, rsp_ready,
    input  cmd_ready, addr_o, data_o, we_o, start_o, rsp_valid, rsp_data, wr_done_cnt, err_o
  );
endinterface

// File: rtl/wb_cmd_sequencer.sv
// Queues read/write commands in a small FIFO and plays them one at a time onto a
// start/busy/valid bus interface. Optional watchdog: define WB_SEQ_TIMEOUT_EN.
module wb_cmd_sequencer #(
  parameter int data_wl    = 16,
  parameter int adr_wl     = 16,
  parameter int depth_log2 = 2,
  parameter int timeout    = 255
) (
  input  logic                 clk,
  input  logic                 a_reset_h,
  wb_cmd_sequencer_if.master   bus
);
  localparam int DEPTH = 1 << depth_log2;

  typedef struct packed {
    logic               we;
    logic [adr_wl-1:0]  addr;
    logic [data_wl-1:0] data;
  } cmd_t;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    ISSUE     = 5'b00010,
    WAIT_BUSY = 5'b00100,
    WAIT_DONE = 5'b01000,
    RESP      = 5'b10000
  } state_t;

  cmd_t                  mem_q [DEPTH];
  logic [depth_log2-1:0] wr_ptr_q, rd_ptr_q;
  logic [depth_log2:0]   cnt_q;
  logic                  push, pop;
  cmd_t                  head;

  state_t                state_q;
  logic [adr_wl-1:0]     addr_q;
  logic [data_wl-1:0]    data_q, rsp_data_q;
  logic                  we_q, start_q, rsp_valid_q;
  logic [7:0]            wr_cnt_q;
  logic                  tmo_hit;

  assign bus.cmd_ready = (cnt_q != (depth_log2+1)'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  // Pop is tied to the IDLE decision, so a freshly pushed entry waits one cycle.
  assign pop           = (state_q == IDLE) && (cnt_q != '0);
  assign head          = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{we: bus.cmd_we, addr: bus.cmd_addr, data: bus.cmd_data};
  end

  always_ff @(posedge clk or posedge a_reset_h) begin
    if (a_reset_h) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge a_reset_h) begin
    if (a_reset_h) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wr_cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (pop) begin
          addr_q  <= head.addr;
          data_q  <= head.data;
          we_q    <= head.we;
          start_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: state_q <= WAIT_BUSY;
        WAIT_BUSY:
          if (tmo_hit)         state_q <= IDLE;
          else if (bus.busy_i) state_q <= WAIT_DONE;
        WAIT_DONE:
          if (tmo_hit) state_q <= IDLE;
          else if (!bus.busy_i && bus.valid_i) begin
            if (we_q) begin
              wr_cnt_q <= wr_cnt_q + 8'd1;
              state_q  <= IDLE;
            end else begin
              rsp_data_q  <= bus.rdata_i;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WB_SEQ_TIMEOUT_EN
  localparam int TW = (timeout < 2) ? 1 : $clog2(timeout + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic          waiting;

  assign waiting = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  // Fires on the edge that would bring the wait count up to the limit.
  assign tmo_hit = waiting && (tmo_q == TW'(timeout - 1));

  always_ff @(posedge clk or posedge a_reset_h) begin
    if (a_reset_h) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (pop)          tmo_q <= '0;
      else if (waiting) tmo_q <= tmo_q + 1'b1;
      if (tmo_hit)      err_q <= 1'b1;
    end
  end
  assign bus.err_o = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^timeout;
  assign tmo_hit    = 1'b0;
  assign bus.err_o  = 1'b0;
`endif

  assign bus.addr_o      = addr_q;
  assign bus.data_o      = data_q;
  assign bus.we_o        = we_q;
  assign bus.start_o     = start_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.wr_done_cnt = wr_cnt_q;
endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Directed bench for wb_cmd_sequencer: vector table plus hand sequences for
// back-pressure, FIFO full, counter wrap, mid-operation reset and the watchdog.
`timescale 1ns/1ps
module tb_wb_cmd_sequencer;
  localparam int DW = 16;
  localparam int AW = 16;
`ifdef WB_SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_cmd_sequencer_if #(.data_wl(DW), .adr_wl(AW)) bus ();
  wb_cmd_sequencer #(.data_wl(DW), .adr_wl(AW), .depth_log2(2), .timeout(TMO)) dut (
    .clk(clk), .a_reset_h(rst), .bus(bus)
  );

  int         errs = 0, checks = 0, starts = 0;
  logic [7:0] exp_wr = 8'd0;

  always @(posedge clk) if (bus.start_o === 1'b1) starts++;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            nb;
    logic [DW-1:0] rd;
    int            hold;
    logic [7:0]    exp_cnt;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 0;
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = a; bus.cmd_data = d;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.cmd_ready) done = 1;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.start_o) ok = 1;
      else @(negedge clk);
    end
    if (!ok) chk("start_timeout", 0, 1);
  endtask

  task automatic serve(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int nb, input logic [DW-1:0] rd, input int hold);
    bit ok;
    int s0;
    wait_start(ok);
    if (ok) begin
      chk("addr_o", bus.addr_o, a);
      chk("data_o", bus.data_o, d);
      chk("we_o", bus.we_o, we);
      s0 = starts;
      bus.busy_i = 1'b1;
      for (int i = 0; i < nb; i++) begin
        @(negedge clk);
        if (i == 0) chk("start_pulse", bus.start_o, 0);
      end
      bus.busy_i = 1'b0; bus.valid_i = 1'b1; bus.rdata_i = rd;
      @(negedge clk);
      bus.valid_i = 1'b0; bus.rdata_i = '0;
      if (we) begin
        exp_wr = exp_wr + 8'd1;
        chk("wr_done_cnt", bus.wr_done_cnt, exp_wr);
        chk("no_rsp_on_write", bus.rsp_valid, 0);
      end else begin
        for (int h = 0; h < hold; h++) begin
          chk("rsp_valid_hold", bus.rsp_valid, 1);
          chk("rsp_data", bus.rsp_data, rd);
          @(negedge clk);
        end
        chk("rsp_valid_last", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_clr", bus.rsp_valid, 0);
      end
      chk("start_count", starts, s0 + 1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_start_o"}, bus.start_o, 0);
    chk({tag, "_addr_o"}, bus.addr_o, 0);
    chk({tag, "_data_o"}, bus.data_o, 0);
    chk({tag, "_we_o"}, bus.we_o, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_wr_done_cnt"}, bus.wr_done_cnt, 0);
    chk({tag, "_err_o"}, bus.err_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int s0, n;
    tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 2, 16'h0000, 1, 8'd1};
    tbl[1] = '{1'b0, 16'h0020, 16'h0000, 2, 16'h1234, 1, 8'd1};
    tbl[2] = '{1'b1, 16'hFFFF, 16'h0000, 3, 16'h0000, 1, 8'd2};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000, 4, 16'hFFFF, 2, 8'd2};
    tbl[4] = '{1'b1, 16'h8001, 16'hA5A5, 2, 16'h0000, 1, 8'd3};
    tbl[5] = '{1'b0, 16'h7FFE, 16'h0000, 2, 16'h5A5A, 1, 8'd3};

    bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.busy_i = 0; bus.valid_i = 0; bus.rdata_i = '0; bus.rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      push(tbl[i].we, tbl[i].addr, tbl[i].data);
      serve(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].nb, tbl[i].rd, tbl[i].hold);
      chk("tbl_cnt", bus.wr_done_cnt, tbl[i].exp_cnt);
    end

    // Read held in RESP for 3 cycles while a write waits behind it.
    push(1'b0, 16'h0020, 16'h0000);
    push(1'b1, 16'h0030, 16'h3030);
    serve(1'b0, 16'h0020, 16'h0000, 2, 16'h1234, 3);
    serve(1'b1, 16'h0030, 16'h3030, 2, 16'h0000, 1);

    // Busy stuck high on A; four more fill the FIFO, the next is held off.
    push(1'b1, 16'h0100, 16'h1111);
    wait_start(ok);
    chk("A_addr", bus.addr_o, 16'h0100);
    bus.busy_i = 1'b1;
    for (int i = 1; i <= 4; i++) push(1'b1, AW'(16'h0100 + i), DW'(16'h1111 * (i + 1)));
    chk("full_ready0", bus.cmd_ready, 0);
    s0 = starts;
    @(negedge clk);
    chk("full_ready1", bus.cmd_ready, 0);
    chk("full_no_start", starts, s0);
    fork
      push(1'b1, 16'h0105, 16'h6666);
      begin
        bus.busy_i = 1'b0; bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        exp_wr = exp_wr + 8'd1;
        chk("A_wr_cnt", bus.wr_done_cnt, exp_wr);
        serve(1'b1, 16'h0101, 16'h2222, 2, 16'h0000, 1);
      end
    join
    for (int i = 2; i <= 5; i++) serve(1'b1, AW'(16'h0100 + i), DW'(16'h1111 * (i + 1)), 2, 16'h0000, 1);

`ifdef WB_SEQ_TIMEOUT_EN
    push(1'b1, 16'h0300, 16'h3333);
    push(1'b1, 16'h0301, 16'h4444);
    wait_start(ok);
    bus.busy_i = 1'b1;
    n = 0;
    while (!bus.err_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 17);
    chk("tmo_err", bus.err_o, 1);
    chk("tmo_no_wr", bus.wr_done_cnt, exp_wr);
    serve(1'b1, 16'h0301, 16'h4444, 2, 16'h0000, 1);
    chk("tmo_sticky", bus.err_o, 1);
`endif

    // Reset while in WAIT_DONE with three commands queued.
    push(1'b1, 16'h0200, 16'h7777);
    wait_start(ok);
    bus.busy_i = 1'b1;
    for (int i = 1; i <= 3; i++) push(1'b1, AW'(16'h0200 + i), 16'h8888);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    bus.busy_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_wr = 8'd0;
    s0 = starts;
    repeat (20) @(negedge clk);
    chk("rst_no_start", starts, s0);
    chk("rst_ready", bus.cmd_ready, 1);

    // 256 writes wrap the completion counter.
    for (int i = 0; i < 256; i++) begin
      push(1'b1, AW'(i), DW'(~i));
      serve(1'b1, AW'(i), DW'(~i), 2, 16'h0000, 1);
      if (i == 254) chk("wr_cnt_255", bus.wr_done_cnt, 8'd255);
    end
    chk("wr_cnt_wrap", bus.wr_done_cnt, 8'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/wb_cmd_sequencer.md
WB_CMD_SEQUENCER -- requirements
Module: wb_cmd_sequencer

Interface
REQ-001 SHALL have parameter data_wl, default 16, data width matching the downstream Wishbone interface.
REQ-002 SHALL have parameter adr_wl, default 16, address width matching the downstream Wishbone interface.
REQ-003 SHALL have parameter depth_log2, default 2, command FIFO depth = 2**depth_log2 entries.
REQ-004 SHALL have parameter timeout, default 255, watchdog limit in cycles (used only with REQ-030).
REQ-005 Ports (name direction width meaning); one clock, asynchronous active-high reset:
- clk  in  1  single clock, all state on rising edge.
- a_reset_h  in  1  asynchronous active-high reset.
- cmd_valid  in  1  upstream command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  adr_wl  command address.
- cmd_data  in  data_wl  write data (ignored for reads).
- addr_o  out  adr_wl  to interface addr_i.
- data_o  out  data_wl  to interface data_i.
- we_o  out  1  to interface we_i.
- start_o  out  1  one-cycle start pulse to interface start_i.
- busy_i  in  1  interface busy_o.
- valid_i  in  1  interface valid_o.
- rdata_i  in  data_wl  interface data_o.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  data_wl  read data.
- wr_done_cnt  out  8  completed writes, wraps 255->0.
- err_o  out  1  sticky watchdog error (0 when REQ-030 disabled).

Function
REQ-006 Command accepted on a rising edge when cmd_valid && cmd_ready; {cmd_we, cmd_addr, cmd_data} written to FIFO tail.
REQ-007 cmd_ready SHALL equal (FIFO count != depth), combinational from registered count.
REQ-008 Simultaneous push and pop SHALL leave count unchanged, both operations performed.
REQ-009 Read/write pointers SHALL be depth_log2 bits wrapping modulo depth; count SHALL be depth_log2+1 bits.
REQ-010 No bypass: a command pushed into an empty FIFO is issued no earlier than the following cycle.
REQ-011 FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP; one-hot encoded.
REQ-012 IDLE -> ISSUE when FIFO non-empty; that edge pops the head into addr_o/data_o/we_o and sets start_o=1.
REQ-013 ISSUE lasts exactly one cycle; start_o=0 on leaving; next state WAIT_BUSY.
REQ-014 WAIT_BUSY -> WAIT_DONE when busy_i=1; otherwise stay.
REQ-015 WAIT_DONE -> completion when busy_i=0 && valid_i=1.
REQ-016 Write completion: wr_done_cnt increments by 1, next state IDLE.
REQ-017 Read completion: rsp_data <= rdata_i, rsp_valid <= 1, next state RESP.
REQ-018 RESP: hold rsp_valid/rsp_data stable; on rsp_ready=1, rsp_valid <= 0 and next state IDLE.
REQ-019 Best-case command-to-command spacing: 5 cycles for writes (ISSUE, WAIT_BUSY, 2 busy cycles, IDLE) with zero-wait-state ack.
REQ-020 addr_o, data_o and we_o SHALL hold their values from ISSUE until the next ISSUE.
REQ-021 Undefined FSM state SHALL go to IDLE.

Reset
REQ-022 a_reset_h=1 SHALL immediately clear state to IDLE, pointers/count to 0, start_o, rsp_valid, we_o, err_o to 0, addr_o, data_o, rsp_data, wr_done_cnt to 0.
REQ-023 Reset mid-operation SHALL discard all queued commands and any pending response; cmd_ready=1 during and after reset.

Configuration
REQ-030 With macro WB_SEQ_TIMEOUT_EN defined: a counter runs in WAIT_BUSY/WAIT_DONE, clears on entering ISSUE; reaching timeout sets err_o=1 (sticky until reset) and forces IDLE, dropping the command (no response, no wr_done_cnt increment).
REQ-031 Without WB_SEQ_TIMEOUT_EN: no counter, err_o tied 0, FSM waits indefinitely.

Verification
REQ-040 Reset, then push write addr=0x0010 data=0xBEEF; interface acks after 1 cycle -> start_o single pulse, addr_o=0x0010, data_o=0xBEEF, we_o=1; wr_done_cnt=1; rsp_valid never set.
REQ-041 Push read addr=0x0020, rdata_i=0x1234 at completion, rsp_ready=0 for 3 cycles -> rsp_valid held 3 cycles with rsp_data=0x1234; no new start_o until rsp_ready=1.
REQ-042 Push 5 commands back-to-back with depth 4 and busy_i held high -> cmd_ready=0 after 4th push, 5th held off until the first pop; all 5 issued in order.
REQ-043 256 writes -> wr_done_cnt wraps to 0.
REQ-044 Assert a_reset_h during WAIT_DONE with 3 queued -> all outputs at reset values, no further start_o after release.
REQ-045 With WB_SEQ_TIMEOUT_EN, timeout=16, busy_i stuck 1 -> err_o=1 at cycle 16 after ISSUE, FSM IDLE, next queued command issued.
